// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave with local word memory, programmable wait states, error responses and write-to-read forwarding
module ahb_slave_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [2:0]  HSize,
  input  logic [31:0] HWData,
  input  logic        HReady,
  output logic [31:0] HRData,
  output logic        HReadyOut,
  output logic [1:0]  HResp
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cnt;
  logic [AW-1:0] r_widx, w_rd_idx;
  logic [1:0]    r_lo, r_size;
  logic          r_write;
  logic [31:0]   r_hrdata;
  logic [31:0]   r_mem [DEPTH];
  logic          w_smp, w_err, w_we, w_rd_load;
  logic [3:0]    w_be;
  logic [31:0]   w_bmask, w_merge, w_rd_word;

  assign HReadyOut = !(r_state inside {S_WAIT, S_ERR1});
  assign HResp     = (r_state inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
  assign HRData    = r_hrdata;

  // A new address phase is only taken while this slave is not stalling the bus
  assign w_smp = HSel && HReady && HReadyOut && (HTrans inside {2'b10, 2'b11});
  assign w_err = (HSize > 3'd2) || (HSize == 3'd1 && HAddr[0]) ||
                 (HSize == 3'd2 && HAddr[1:0] != 2'b00) || (HAddr[31:2] >= 30'(DEPTH));

  // Byte lanes of the committing write and the word as it will look after the commit
  assign w_we    = (r_state == S_LAST) && r_write;
  assign w_be    = (r_size == 2'd0) ? 4'b0001 << r_lo :
                   (r_size == 2'd1) ? (r_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_bmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_merge = (HWData & w_bmask) | (r_mem[r_widx] & ~w_bmask);

  // Read data is captured on the edge entering LAST; a same-edge write to that word is forwarded
  assign w_rd_idx  = (r_state == S_WAIT) ? r_widx : HAddr[AW+1:2];
  assign w_rd_word = (w_we && w_rd_idx == r_widx) ? w_merge : r_mem[w_rd_idx];
  assign w_rd_load = (w_next == S_LAST) && ((r_state == S_WAIT) ? !r_write : !HWrite);

  // Next-state and wait counter: stall states run to completion, ready states may accept a new transfer
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    if (r_state == S_WAIT) begin
      w_cnt  = r_cnt - 4'd1;
      w_next = (r_cnt == 4'd1) ? S_LAST : S_WAIT;
    end else if (r_state == S_ERR1) begin
      w_next = S_ERR2;
    end else if (w_smp) begin
      w_next = w_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_LAST);
      w_cnt  = w_err ? 4'd0 : 4'(WAIT_STATES);
    end else begin
      w_next = S_IDLE;
    end
  end

  // State, counter, captured address phase and read data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_widx   <= '0;
      r_lo     <= 2'd0;
      r_size   <= 2'd0;
      r_write  <= 1'b0;
      r_hrdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_smp) begin
        r_widx  <= HAddr[AW+1:2];
        r_lo    <= HAddr[1:0];
        r_size  <= HSize[1:0];
        r_write <= HWrite;
      end
      if (w_rd_load) r_hrdata <= w_rd_word;
    end
  end

  // Memory array is never reset; a write lands only on the edge that ends its LAST cycle
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_widx] <= w_merge;
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed AHB transfers against two slaves (1 and 0 wait states) checked by a transaction-level model
module tb_ahb_slave_mem;
  localparam int WS0 = 1;
  localparam int WS1 = 0;
  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic        clk = 0, rst = 1;
  logic        sel0 = 0, sel1 = 0, hwrite = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0]  htrans = 0;
  logic [2:0]  hsize = 0;
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1;
  logic [1:0]  resp0, resp1;
  int          checks = 0, errors = 0;
  int          lowcnt[2], respcnt[2];

  always #5 clk = ~clk;

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst), .HSel(sel0), .HAddr(haddr), .HTrans(htrans), .HWrite(hwrite),
    .HSize(hsize), .HWData(hwdata), .HReady(rdy0), .HRData(rdata0), .HReadyOut(rdy0), .HResp(resp0));

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst), .HSel(sel1), .HAddr(haddr), .HTrans(htrans), .HWrite(hwrite),
    .HSize(hsize), .HWData(hwdata), .HReady(rdy1), .HRData(rdata1), .HReadyOut(rdy1), .HResp(resp1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad(input logic [31:0] a, input logic [2:0] sz);
    return sz > 3'd2 || (a % (32'd1 << sz)) != 0 || (a >> 2) >= 32'd256;
  endfunction

  // Transaction model: each accepted transfer owns the bus for (wait states + 1) cycles, errors for 2
  int          m_low[2];
  logic        m_act[2], m_wr[2], m_err[2];
  logic [31:0] m_addr[2], m_rd[2], m_hrdata[2];
  logic [2:0]  m_sz[2];
  logic [31:0] ref_mem[2][256];

  initial forever begin
    @(posedge clk or posedge rst);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_low[k] = 0; m_act[k] = 0; m_err[k] = 0; m_wr[k] = 0; m_hrdata[k] = 0;
      end else if (m_low[k] > 0) begin
        m_low[k]--;
        if (m_low[k] == 0 && m_act[k] && !m_wr[k] && !m_err[k]) m_hrdata[k] = m_rd[k];
      end else begin
        if (m_act[k] && m_wr[k] && !m_err[k])
          for (int b = 0; b < 4; b++)
            if (b >= int'(m_addr[k][1:0]) && b < int'(m_addr[k][1:0]) + (1 << m_sz[k]))
              ref_mem[k][m_addr[k][9:2]][8*b +: 8] = hwdata[8*b +: 8];
        m_act[k]  = (k == 0 ? sel0 : sel1) && htrans[1];
        m_err[k]  = m_act[k] && bad(haddr, hsize);
        m_wr[k]   = hwrite;
        m_addr[k] = haddr;
        m_sz[k]   = hsize;
        m_low[k]  = !m_act[k] ? 0 : m_err[k] ? 1 : (k == 0 ? WS0 : WS1);
        if (m_act[k] && !m_wr[k] && !m_err[k]) begin
          m_rd[k] = ref_mem[k][haddr[9:2]];
          if (m_low[k] == 0) m_hrdata[k] = m_rd[k];
        end
      end
    end
  end

  // Compare both slaves against the model every cycle, and tally stall/error cycles
  initial forever begin
    @(negedge clk);
    chk("hreadyout0", 32'(rdy0), 32'(m_low[0] == 0));
    chk("hresp0", 32'(resp0), 32'(m_err[0]));
    chk("hrdata0", rdata0, m_hrdata[0]);
    chk("hreadyout1", 32'(rdy1), 32'(m_low[1] == 0));
    chk("hresp1", 32'(resp1), 32'(m_err[1]));
    chk("hrdata1", rdata1, m_hrdata[1]);
    if (!rdy0) lowcnt[0]++;
    if (!rdy1) lowcnt[1]++;
    if (resp0 == 2'b01) respcnt[0]++;
    if (resp1 == 2'b01) respcnt[1]++;
  end

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;
  beat_t beats[$];

  task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.tr = tr; b.wr = wr; b.sz = sz; b.a = a; b.d = d;
    beats.push_back(b);
  endtask

  task automatic put(input int k, input int i);
    sel0 = k == 0;
    sel1 = k == 1;
    if (i < beats.size()) begin
      htrans = beats[i].tr; hwrite = beats[i].wr; hsize = beats[i].sz; haddr = beats[i].a;
    end else begin
      htrans = IDL; hwrite = 0;
    end
  endtask

  // Pipelined master: the next address phase advances only on edges where the slave was ready
  task automatic run(input int k, output int cyc);
    int   i = 0;
    logic rdy;
    lowcnt[0] = 0; lowcnt[1] = 0; respcnt[0] = 0; respcnt[1] = 0;
    cyc = 0;
    put(k, 0);
    while (i <= beats.size() && cyc < 200) begin
      @(negedge clk);
      rdy = (k == 0) ? rdy0 : rdy1;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) begin
        if (i < beats.size()) hwdata = beats[i].d;
        i++;
        put(k, i);
      end
    end
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL run_timeout: got %0d cycles expected completion", cyc);
    end
    beats.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    @(posedge clk); #2;
    chk("rst_hrdata0", rdata0, 32'h0);
    chk("rst_ready1", 32'(rdy1), 32'h1);
    chk("rst_resp0", 32'(resp0), 32'h0);
    @(posedge clk); #1 rst = 0;

    add(NS, 1, 3'd2, 32'h10, 32'hDEADBEEF); add(NS, 0, 3'd2, 32'h10, 0); run(0, cyc);
    chk("ws1_read", rdata0, 32'hDEADBEEF);
    chk("ws1_stalls", lowcnt[0], 2);
    chk("ws1_errcycles", respcnt[0], 0);

    add(NS, 1, 3'd2, 32'h20, 32'h11223344); add(NS, 0, 3'd2, 32'h20, 0); run(1, cyc);
    chk("ws0_forward", rdata1, 32'h11223344);
    chk("ws0_stalls", lowcnt[1], 0);
    chk("ws0_cycles", cyc, 3);

    add(NS, 1, 3'd0, 32'h21, 32'h0000AB00); add(NS, 0, 3'd2, 32'h20, 0); run(1, cyc);
    chk("byte_merge", rdata1, 32'h1122AB44);

    add(NS, 1, 3'd1, 32'h22, 32'h77660000); add(IDL, 0, 3'd2, 32'h0, 0); add(NS, 0, 3'd0, 32'h23, 0); run(1, cyc);
    chk("half_merge", rdata1, 32'h7766AB44);

    add(NS, 0, 3'd3, 32'h28, 0); run(1, cyc);
    chk("size_err_stalls", lowcnt[1], 1);
    chk("size_err_cycles", respcnt[1], 2);

    add(NS, 1, 3'd2, 32'h00, 32'hCAFEF00D); run(0, cyc);
    add(NS, 0, 3'd2, 32'h400, 0); add(NS, 1, 3'd1, 32'h03, 32'h55555555); run(0, cyc);
    chk("err_stalls", lowcnt[0], 2);
    chk("err_cycles", respcnt[0], 4);
    add(NS, 0, 3'd2, 32'h00, 0); run(0, cyc);
    chk("err_mem_kept", rdata0, 32'hCAFEF00D);

    add(NS, 1, 3'd2, 32'h40, 32'h01010101); add(SQ, 1, 3'd2, 32'h44, 32'h02020202);
    add(BSY, 1, 3'd2, 32'h48, 0);
    add(SQ, 1, 3'd2, 32'h48, 32'h03030303); add(SQ, 1, 3'd2, 32'h4C, 32'h04040404); run(0, cyc);
    chk("burst_stalls", lowcnt[0], 4);
    chk("burst_errcycles", respcnt[0], 0);
    add(NS, 0, 3'd2, 32'h40, 0); add(SQ, 0, 3'd2, 32'h44, 0);
    add(SQ, 0, 3'd2, 32'h48, 0); add(SQ, 0, 3'd2, 32'h4C, 0); run(0, cyc);
    chk("burst_last_read", rdata0, 32'h04040404);

    add(NS, 1, 3'd2, 32'h30, 32'h0BADF00D); run(0, cyc);
    sel0 = 1; sel1 = 0; haddr = 32'h30; hwrite = 1; hsize = 3'd2; htrans = NS;
    @(posedge clk); #1;
    hwdata = 32'hFFFFFFFF; htrans = IDL; hwrite = 0;
    chk("abort_in_wait", 32'(rdy0), 32'h0);
    #2 rst = 1;
    #1;
    chk("abort_ready", 32'(rdy0), 32'h1);
    chk("abort_resp", 32'(resp0), 32'h0);
    chk("abort_hrdata", rdata0, 32'h0);
    @(negedge clk); #2 rst = 0;
    add(NS, 0, 3'd2, 32'h30, 0); run(0, cyc);
    chk("abort_no_commit", rdata0, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in local memory (power of two).
REQ-002 Parameter WAIT_STATES, default 1, number of HReadyOut-low cycles inserted per OKAY transfer (0..15).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 HSel  input  1  slave select.
REQ-006 HAddr  input  32  byte address, address phase.
REQ-007 HTrans  input  2  IDLE=00, BUSY=01, NON_SEQ=10, SEQ=11.
REQ-008 HWrite  input  1  1=write, 0=read, address phase.
REQ-009 HSize  input  3  000 byte, 001 halfword, 010 word.
REQ-010 HWData  input  32  write data, data phase.
REQ-011 HReady  input  1  bus-level ready (previous transfer complete).
REQ-012 HRData  output  32  read data, valid when HReadyOut=1 in a read data phase.
REQ-013 HReadyOut  output  1  slave ready; 0 extends the data phase.
REQ-014 HResp  output  2  OKAY=00, ERROR=01.

Function
REQ-015 Address phase SHALL be sampled only when HSel=1, HReady=1 and HTrans is NON_SEQ or SEQ; address, HWrite and HSize are registered at that edge.
REQ-016 IDLE or BUSY with HSel=1, or HSel=0, SHALL produce a zero-wait OKAY data phase (HReadyOut=1, HResp=00) and no memory access.
REQ-017 A sampled transfer is an error if HSize>010, HAddr not aligned to HSize, or HAddr[31:2]>=DEPTH.
REQ-018 FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
REQ-019 IDLE: valid non-error transfer -> WAIT with counter=WAIT_STATES if WAIT_STATES>0, else -> LAST; error transfer -> ERR1; otherwise stay.
REQ-020 WAIT: HReadyOut=0, HResp=00, counter decrements each cycle; counter reaching 1 -> LAST.
REQ-021 LAST: HReadyOut=1, HResp=00; write commits HWData to memory at this edge; read drives HRData; if a new valid transfer is sampled this same edge, re-enter WAIT/LAST/ERR1 per REQ-019, else -> IDLE.
REQ-022 ERR1: HReadyOut=0, HResp=01, no memory access -> ERR2.
REQ-023 ERR2: HReadyOut=1, HResp=01; a transfer sampled at this edge is processed per REQ-019; else -> IDLE.
REQ-024 Writes SHALL update only byte lanes selected by HSize and HAddr[1:0] (byte: lane HAddr[1:0]; halfword: lanes 1:0 or 3:2; word: all).
REQ-025 Reads SHALL return the full addressed word on HRData regardless of HSize.
REQ-026 Read whose address phase coincides with the commit edge of a write to the same word SHALL return the merged post-write word (forwarding), never stale data.
REQ-027 HRData SHALL hold its last read value outside read data phases; HResp SHALL be 00 except in ERR1/ERR2.
REQ-028 Back-to-back transfers with WAIT_STATES=0 SHALL complete one per cycle with HReadyOut continuously 1.
REQ-029 BUSY inserted inside a burst SHALL not disturb the in-progress data phase and SHALL not be sampled as a transfer.

Reset
REQ-030 On rst=1, asynchronously: state=IDLE, counter=0, HReadyOut=1, HResp=00, HRData=0, registered address-phase fields cleared.
REQ-031 Reset during WAIT or ERR1 SHALL abandon the transfer; a pending write SHALL NOT commit.
REQ-032 Memory contents are not reset.

Verification
REQ-033 WAIT_STATES=1: NON_SEQ word write 0xDEADBEEF to 0x10, then read 0x10 -> each data phase HReadyOut low 1 cycle, read returns 0xDEADBEEF, HResp=00.
REQ-034 WAIT_STATES=0: write 0x11223344 to 0x20 immediately followed by read 0x20 -> read data 0x11223344 in next cycle, HReadyOut stays 1.
REQ-035 Byte write 0xAB to 0x21 over word 0x11223344 -> read 0x20 returns 0x1122AB44.
REQ-036 Read at HAddr=0x400 (DEPTH=256) and halfword write to 0x03 -> each gives HReadyOut 0 then 1 with HResp=01 both cycles; memory unchanged.
REQ-037 4-beat SEQ burst with one BUSY between beats 2 and 3 -> four OKAY completions, BUSY cycle OKAY zero-wait, memory holds all four words.
REQ-038 Assert rst in WAIT of a write to 0x30 -> HReadyOut=1, HResp=00 immediately; later read 0x30 returns prior contents.
